// File: rtl/bus_cycle_ctrl.sv
// 68000 bus cycle sequencer: turns registered decoder selects into DTACK/VPA/BERR
// and drives the 6800-style E clock, VMA and peripheral strobes.
module bus_cycle_ctrl #(
  parameter int MEM_WAIT     = 0,
  parameter int E_DIV        = 10,
  parameter int E_HIGH       = 4,
  parameter int BERR_TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic as_n,
  input  logic rw,
  input  logic sel_dtack_n,
  input  logic sel_vpa_n,
  input  logic sel_avec_n,
  output logic cpu_dtack_n,
  output logic cpu_vpa_n,
  output logic cpu_berr_n,
  output logic e_clk,
  output logic vma_n,
  output logic periph_rd_n,
  output logic periph_wr_n,
  output logic periph_stb,
  output logic busy
);

  localparam int EW   = (E_DIV > 1) ? $clog2(E_DIV) : 1;
  localparam int CMAX = (MEM_WAIT > BERR_TIMEOUT) ? MEM_WAIT : BERR_TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [EW-1:0] E_LAST = EW'(E_DIV - 1);
  localparam logic [EW-1:0] E_RISE = EW'(E_DIV - E_HIGH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MEM_WAIT,
    ST_AVEC,
    ST_VPA_SYNC,
    ST_VPA_ACTIVE,
    ST_BERR_WAIT,
    ST_ACKED
  } state_t;

  state_t        state, state_nx;
  logic [EW-1:0] e_cnt, e_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          e_fall, e_hi_nx;
  logic          dtack_nx, vpa_nx, berr_nx, vma_nx, rd_nx, wr_nx, stb_nx;

  // E phase runs free; every E-derived output is computed from the phase after the edge
  assign e_fall  = (e_cnt == E_LAST);
  assign e_nx    = e_fall ? '0 : e_cnt + EW'(1);
  assign e_hi_nx = (e_nx >= E_RISE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      e_cnt       <= '0;
      cnt         <= '0;
      cpu_dtack_n <= 1'b1;
      cpu_vpa_n   <= 1'b1;
      cpu_berr_n  <= 1'b1;
      e_clk       <= 1'b0;
      vma_n       <= 1'b1;
      periph_rd_n <= 1'b1;
      periph_wr_n <= 1'b1;
      periph_stb  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nx;
      e_cnt       <= e_nx;
      cnt         <= cnt_nx;
      cpu_dtack_n <= dtack_nx;
      cpu_vpa_n   <= vpa_nx;
      cpu_berr_n  <= berr_nx;
      e_clk       <= e_hi_nx;
      vma_n       <= vma_nx;
      periph_rd_n <= rd_nx;
      periph_wr_n <= wr_nx;
      periph_stb  <= stb_nx;
      busy        <= (state_nx != ST_IDLE);
    end
  end

  // Handshake outputs hold by default; AS going high always wins over cycle progress
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    dtack_nx = cpu_dtack_n;
    vpa_nx   = cpu_vpa_n;
    berr_nx  = cpu_berr_n;
    vma_nx   = vma_n;
    rd_nx    = periph_rd_n;
    wr_nx    = periph_wr_n;
    stb_nx   = 1'b0;

    if (state == ST_IDLE) begin
      if (!as_n) begin
        if (!sel_avec_n) begin
          vpa_nx   = 1'b0;
          state_nx = ST_AVEC;
        end else if (!sel_dtack_n) begin
          if (MEM_WAIT == 0) begin
            dtack_nx = 1'b0;
            state_nx = ST_ACKED;
          end else begin
            cnt_nx   = CW'(MEM_WAIT);
            state_nx = ST_MEM_WAIT;
          end
        end else if (!sel_vpa_n) begin
          vpa_nx   = 1'b0;
          state_nx = ST_VPA_SYNC;
        end else begin
          cnt_nx   = CW'(1);
          state_nx = ST_BERR_WAIT;
        end
      end
    end else if (as_n) begin
      state_nx = ST_IDLE;
      cnt_nx   = '0;
      dtack_nx = 1'b1;
      vpa_nx   = 1'b1;
      berr_nx  = 1'b1;
      vma_nx   = 1'b1;
      rd_nx    = 1'b1;
      wr_nx    = 1'b1;
    end else begin
      case (state)
        ST_MEM_WAIT: begin
          if (cnt == '0) begin
            dtack_nx = 1'b0;
            state_nx = ST_ACKED;
          end else begin
            cnt_nx = cnt - CW'(1);
          end
        end
        ST_VPA_SYNC: begin
          if (e_fall) begin
            vma_nx   = 1'b0;
            state_nx = ST_VPA_ACTIVE;
          end
        end
        ST_VPA_ACTIVE: begin
          if (e_fall) begin
            stb_nx   = 1'b1;
            rd_nx    = 1'b1;
            wr_nx    = 1'b1;
            dtack_nx = 1'b0;
            state_nx = ST_ACKED;
          end else begin
            rd_nx = ~(e_hi_nx & rw);
            wr_nx = ~(e_hi_nx & ~rw);
          end
        end
        ST_BERR_WAIT: begin
          if (cnt == CW'(BERR_TIMEOUT)) begin
            berr_nx  = 1'b0;
            state_nx = ST_ACKED;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed bench for bus_cycle_ctrl: an edge-indexed window model predicts every
// output after each clock, and literal checks pin the key edges of each scenario.
module tb_bus_cycle_ctrl;

  localparam int MEM_WAIT     = 2;
  localparam int E_DIV        = 10;
  localparam int E_HIGH       = 4;
  localparam int BERR_TIMEOUT = 64;

  localparam int K_DT = 0;
  localparam int K_VP = 1;
  localparam int K_AV = 2;
  localparam int K_NO = 3;

  localparam logic [8:0] RST_VEC = 9'b111011100;

  logic clk = 1'b0;
  logic reset_n, as_n, rw, sel_dtack_n, sel_vpa_n, sel_avec_n;
  logic cpu_dtack_n, cpu_vpa_n, cpu_berr_n, e_clk, vma_n;
  logic periph_rd_n, periph_wr_n, periph_stb, busy;
  logic [8:0] outs;

  int n_vec = 0;
  int n_err = 0;
  int edge_t = 0;

  always #5 clk = ~clk;

  bus_cycle_ctrl #(
    .MEM_WAIT(MEM_WAIT), .E_DIV(E_DIV), .E_HIGH(E_HIGH), .BERR_TIMEOUT(BERR_TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .as_n(as_n), .rw(rw),
    .sel_dtack_n(sel_dtack_n), .sel_vpa_n(sel_vpa_n), .sel_avec_n(sel_avec_n),
    .cpu_dtack_n(cpu_dtack_n), .cpu_vpa_n(cpu_vpa_n), .cpu_berr_n(cpu_berr_n),
    .e_clk(e_clk), .vma_n(vma_n), .periph_rd_n(periph_rd_n), .periph_wr_n(periph_wr_n),
    .periph_stb(periph_stb), .busy(busy)
  );

  assign outs = {cpu_dtack_n, cpu_vpa_n, cpu_berr_n, e_clk, vma_n,
                 periph_rd_n, periph_wr_n, periph_stb, busy};

  task automatic check_output(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s at edge %0d: got %b, want %b", name, edge_t, act, exp);
    end
  endtask

  task automatic wait_neg(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Hold off until the next sampling edge lands on the requested E phase
  task automatic align_phase(input int ph);
    while (((edge_t + 1) % E_DIV) != ph) wait_neg(1);
  endtask

  task automatic apply_stimulus(input logic dt, input logic vp, input logic av, input logic r);
    sel_dtack_n = dt;
    sel_vpa_n   = vp;
    sel_avec_n  = av;
    rw          = r;
    as_n        = 1'b0;
  endtask

  task automatic release_bus();
    as_n        = 1'b1;
    sel_dtack_n = 1'b1;
    sel_vpa_n   = 1'b1;
    sel_avec_n  = 1'b1;
  endtask

  // Model: each cycle is a start edge plus windows measured in edges since reset release
  initial begin
    logic s_rst, s_as, s_rw, s_dt, s_vp, s_av;
    logic active;
    int kind, n0, f1, f2;
    logic [8:0] exp;
    active = 1'b0;
    kind = K_NO; n0 = 0; f1 = 0; f2 = 0;
    forever begin
      @(posedge clk);
      s_rst = reset_n; s_as = as_n; s_rw = rw;
      s_dt = sel_dtack_n; s_vp = sel_vpa_n; s_av = sel_avec_n;
      #1;
      if (!s_rst) begin
        edge_t = 0;
        active = 1'b0;
        exp = RST_VEC;
      end else begin
        logic dt, vp, be, vm, rd, wr, st, bz, e;
        edge_t++;
        if (!active && !s_as) begin
          active = 1'b1;
          n0 = edge_t;
          kind = !s_av ? K_AV : !s_dt ? K_DT : !s_vp ? K_VP : K_NO;
          f1 = ((n0 / E_DIV) + 1) * E_DIV;
          f2 = f1 + E_DIV;
        end else if (active && s_as) begin
          active = 1'b0;
        end
        e  = (edge_t % E_DIV) >= (E_DIV - E_HIGH);
        dt = 1'b1; vp = 1'b1; be = 1'b1; vm = 1'b1;
        rd = 1'b1; wr = 1'b1; st = 1'b0; bz = active;
        if (active) begin
          case (kind)
            K_DT: dt = !(edge_t >= n0 + MEM_WAIT + 1);
            K_AV: vp = 1'b0;
            K_VP: begin
              vp = 1'b0;
              vm = !(edge_t >= f1);
              if (edge_t >= f2 - E_HIGH && edge_t < f2) begin
                if (s_rw) rd = 1'b0;
                else      wr = 1'b0;
              end
              st = (edge_t == f2);
              dt = !(edge_t >= f2);
            end
            default: be = !(edge_t >= n0 + BERR_TIMEOUT);
          endcase
        end
        exp = {dt, vp, be, e, vm, rd, wr, st, bz};
      end
      check_output("cycle_model", outs, exp);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    release_bus();
    rw = 1'b1;
    wait_neg(3);
    check_output("reset_state", outs, RST_VEC);
    reset_n = 1'b1;
    wait_neg(2);

    // RAM read with two wait states
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1);
    wait_neg(3);
    check_output("ram_wait_n2", 9'(cpu_dtack_n), 9'd1);
    wait_neg(1);
    check_output("ram_dtack_n3", 9'(cpu_dtack_n), 9'd0);
    wait_neg(2);
    release_bus();
    wait_neg(1);
    check_output("ram_release", 9'({cpu_dtack_n, busy}), 9'b10);
    wait_neg(1);

    // POKEY write starting on E phase 3
    align_phase(3);
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0);
    for (int j = 0; j <= 18; j++) begin
      wait_neg(1);
      if (j == 0)  check_output("vpa_n_at_n", 9'(cpu_vpa_n), 9'd0);
      if (j == 6)  check_output("vma_before_fall", 9'(vma_n), 9'd1);
      if (j == 7)  check_output("vma_at_fall", 9'(vma_n), 9'd0);
      if (j == 12) check_output("wr_before_e", 9'(periph_wr_n), 9'd1);
      if (j == 13) check_output("wr_start", 9'(periph_wr_n), 9'd0);
      if (j == 16) check_output("wr_end", 9'(periph_wr_n), 9'd0);
      if (j == 17) check_output("stb_dtack", 9'({periph_stb, cpu_dtack_n, periph_wr_n}), 9'b101);
      if (j == 18) check_output("stb_one_clk", 9'({periph_stb, cpu_dtack_n}), 9'b00);
    end
    release_bus();
    wait_neg(1);
    check_output("vpa_release", 9'({cpu_vpa_n, vma_n, cpu_dtack_n, busy}), 9'b1110);
    wait_neg(1);

    // Interrupt acknowledge: autovector beats VPA
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1);
    wait_neg(25);
    check_output("avec_hold", 9'({cpu_vpa_n, vma_n, cpu_dtack_n}), 9'b011);
    release_bus();
    wait_neg(2);

    // Unmapped access times out into bus error
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1);
    wait_neg(64);
    check_output("berr_n63", 9'(cpu_berr_n), 9'd1);
    wait_neg(1);
    check_output("berr_n64", 9'(cpu_berr_n), 9'd0);
    wait_neg(2);
    release_bus();
    wait_neg(1);
    check_output("berr_release", 9'({cpu_berr_n, busy}), 9'b10);
    wait_neg(1);

    // Abort during VPA_SYNC, then a normal RAM cycle
    align_phase(3);
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0);
    wait_neg(3);
    release_bus();
    wait_neg(1);
    check_output("abort_release", 9'({cpu_vpa_n, periph_stb, busy}), 9'b100);
    wait_neg(15);
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1);
    wait_neg(4);
    check_output("abort_ram_dtack", 9'(cpu_dtack_n), 9'd0);
    release_bus();
    wait_neg(2);

    // Asynchronous reset in the middle of a peripheral read
    align_phase(3);
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1);
    wait_neg(15);
    check_output("vpa_read_strobe", 9'(periph_rd_n), 9'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("async_reset", outs, RST_VEC);
    release_bus();
    wait_neg(2);
    reset_n = 1'b1;
    wait_neg(5);
    check_output("e_low_after_rst", 9'(e_clk), 9'd0);
    wait_neg(1);
    check_output("e_high_after_rst", 9'(e_clk), 9'd1);
    wait_neg(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bus_cycle_ctrl.md
Name: bus_cycle_ctrl

Overview:
- Sequences every 68000 bus cycle using the registered select strobes from the address-decode PAL (dtack, vpa, avec).
- Generates the CPU handshake: DTACK with programmable wait states, VPA, and bus error on timeout.
- Generates the 6800-style E clock, VMA and strobes for the I/O and POKEY peripherals, which sit on the synchronous peripheral path.
- Placement: between the decoder outputs and the CPU core, inside the CPU subsystem.

Parameters:
- MEM_WAIT, 0: extra clocks inserted before DTACK on decoder-dtack cycles.
- E_DIV, 10: E clock period in clk cycles; minimum 4.
- E_HIGH, 4: number of clocks per E period that E is high; must be less than E_DIV.
- BERR_TIMEOUT, 64: clocks from AS low with no select active until bus error.

Ports:
- clk, in, 1: system clock, rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- as_n, in, 1: CPU address strobe.
- rw, in, 1: CPU read (1) / write (0).
- sel_dtack_n, in, 1: decoder DTACK select, active low.
- sel_vpa_n, in, 1: decoder VPA select, active low.
- sel_avec_n, in, 1: decoder autovector select, active low.
- cpu_dtack_n, out, 1: DTACK to CPU.
- cpu_vpa_n, out, 1: VPA to CPU.
- cpu_berr_n, out, 1: BERR to CPU.
- e_clk, out, 1: E clock.
- vma_n, out, 1: valid memory address, peripheral cycle.
- periph_rd_n, out, 1: peripheral read strobe.
- periph_wr_n, out, 1: peripheral write strobe.
- periph_stb, out, 1: one-clock pulse at E falling edge that ends a peripheral access.
- busy, out, 1: high when the FSM is not in IDLE.

Behaviour:
- Reset:
  - All outputs are registered.
  - On reset, all active-low outputs are 1; e_clk, periph_stb and busy are 0.
  - e_cnt=0, FSM=IDLE, timeout counter=0.
- E clock:
  - e_cnt runs 0..E_DIV-1 and wraps continuously. It is independent of bus activity.
  - e_clk=1 when e_cnt >= E_DIV-E_HIGH.
  - The "E fall" event is the edge where e_cnt goes from E_DIV-1 to 0.
- FSM states: IDLE, MEM_WAIT, AVEC, VPA_SYNC, VPA_ACTIVE, BERR_WAIT, ACKED.
- IDLE: at the first edge sampling as_n=0, the next state is chosen by priority avec > dtack > vpa > none.
  - avec: cpu_vpa_n=0 at that edge; go to AVEC.
  - dtack:
    - MEM_WAIT=0: cpu_dtack_n=0 at that edge; go to ACKED.
    - Otherwise load the wait counter and go to MEM_WAIT.
  - vpa: cpu_vpa_n=0 at that edge; go to VPA_SYNC.
  - none: go to BERR_WAIT; the timeout counter is 1 after that edge.
- MEM_WAIT: decrement the counter. When it reaches 0, cpu_dtack_n=0 and go to ACKED.
  - Net result: DTACK falls MEM_WAIT+1 edges after AS is first sampled low.
- VPA_SYNC: at the next E fall, vma_n=0; go to VPA_ACTIVE.
  - An E fall coinciding with the sampling edge does not count.
- VPA_ACTIVE:
  - While e_clk=1: periph_rd_n = ~rw and periph_wr_n = rw; the selected strobe is 0.
  - At the next E fall:
    - periph_stb=1 for that one clock.
    - Both periph strobes return to 1.
    - cpu_dtack_n=0.
    - Go to ACKED.
  - vma_n stays 0 until AS goes high.
  - Worst-case VPA cycle: 2*E_DIV+1 clocks.
- BERR_WAIT: the timeout counter increments each clock. When it reaches BERR_TIMEOUT, cpu_berr_n=0 and go to ACKED.
  - Decoder selects arriving late in this state are ignored.
- AVEC and ACKED: hold the asserted outputs until as_n is sampled 1.
- Return to IDLE, in any non-IDLE state:
  - At the edge that samples as_n=1, all handshake and peripheral outputs deassert and the FSM goes to IDLE.
  - This applies mid-cycle too (abort). An aborted VPA cycle produces no periph_stb.
- Back-to-back cycles: a new AS low is recognised no earlier than the clock after the return to IDLE.
- Selects are sampled only in IDLE; changes during a cycle are ignored.
- Reset mid-cycle takes effect immediately and asynchronously to the reset values; e_cnt restarts at 0.

Test Plan:
All cases use MEM_WAIT=2, E_DIV=10, E_HIGH=4, BERR_TIMEOUT=64.
1. RAM read: sel_dtack_n=0, AS sampled low at edge N -> cpu_dtack_n=0 from edge N+3; after AS high at edge M, cpu_dtack_n=1 and busy=0 at M.
2. POKEY write: sel_vpa_n=0, AS sampled low at edge N with e_cnt=3 after the edge ->
   - cpu_vpa_n=0 at N.
   - vma_n=0 at N+7 (E fall).
   - periph_wr_n=0 from N+13 through N+16.
   - periph_stb=1 and cpu_dtack_n=0 at N+17.
   - periph_rd_n stays 1 throughout.
3. Interrupt ack: sel_avec_n=0 and sel_vpa_n=0 together -> AVEC wins; cpu_vpa_n=0, vma_n never asserts, cpu_dtack_n stays 1.
4. Unmapped access: no select, AS held low -> cpu_berr_n=0 exactly 64 edges after the sampling edge; cleared on AS high.
5. Abort: VPA cycle with AS released during VPA_SYNC -> outputs deassert that edge, no periph_stb; the next RAM cycle completes normally.
6. Reset: assert reset_n=0 mid-VPA_ACTIVE between edges -> all outputs at reset values with no clock edge; e_cnt restarts at 0 on release.
